// File: rtl/mmcm_lock_supervisor_pkg.sv
// Shared types and sizing helpers for the MMCM lock supervisor.
// Holds the FSM state encoding and the cycle-counter width calculation.
package clk_mgmt_pkg;

    typedef enum logic [2:0] {
        ASSERT_RST,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } lock_state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One extra bit above the largest terminal count keeps the compare unambiguous.
    function automatic int cnt_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c)) + 1;
    endfunction

endpackage

// File: rtl/mmcm_lock_supervisor_if.sv
// MMCM control/status bundle between the lock supervisor and its surroundings.
// master = supervisor side, slave = MMCM/system side.
interface mmcm_lock_supervisor_if;
    import clk_mgmt_pkg::*;

    logic               mmcm_locked_i;
    logic               relock_req_i;
    logic               mmcm_rst_o;
    logic               sys_rst_n_o;
    logic               ready_o;
    logic               fail_o;
    logic [RETRY_W-1:0] retry_cnt_o;
    logic [LOSS_W-1:0]  lock_loss_cnt_o;

    modport master (
        input  mmcm_locked_i,
        input  relock_req_i,
        output mmcm_rst_o,
        output sys_rst_n_o,
        output ready_o,
        output fail_o,
        output retry_cnt_o,
        output lock_loss_cnt_o
    );

    modport slave (
        output mmcm_locked_i,
        output relock_req_i,
        input  mmcm_rst_o,
        input  sys_rst_n_o,
        input  ready_o,
        input  fail_o,
        input  retry_cnt_o,
        input  lock_loss_cnt_o
    );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous level signal.
// Output is the input delayed by SYNC_STAGES clock edges.
module bit_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (!reset_n) sync_reg[gi] <= 1'b0;
                    else          sync_reg[gi] <= d;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (!reset_n) sync_reg[gi] <= 1'b0;
                    else          sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/mmcm_lock_supervisor.sv
// Drives MMCM RST, waits for a debounced LOCKED with timeout and bounded retries,
// then releases the downstream reset request. Runs entirely on the MMCM input clock.
module mmcm_lock_supervisor
    import clk_mgmt_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 12500,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES         = 7,
    parameter int SYNC_STAGES         = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    mmcm_lock_supervisor_if.master bus
);

    localparam int CNT_W = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);
    localparam logic [LOSS_W-1:0]  LOSS_SAT    = '1;

    logic locked_s;

    lock_state_t        state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [RETRY_W-1:0] retry_reg, retry_next;
    logic [LOSS_W-1:0]  loss_reg, loss_next;

    logic mmcm_rst_reg, mmcm_rst_next;
    logic sys_rst_n_reg, sys_rst_n_next;
    logic ready_reg, ready_next;
    logic fail_reg, fail_next;

    bit_synchronizer #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_locked_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (bus.mmcm_locked_i),
        .q       (locked_s)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg     <= ASSERT_RST;
            cnt_reg       <= '0;
            retry_reg     <= '0;
            loss_reg      <= '0;
            mmcm_rst_reg  <= 1'b1;
            sys_rst_n_reg <= 1'b0;
            ready_reg     <= 1'b0;
            fail_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            retry_reg     <= retry_next;
            loss_reg      <= loss_next;
            mmcm_rst_reg  <= mmcm_rst_next;
            sys_rst_n_reg <= sys_rst_n_next;
            ready_reg     <= ready_next;
            fail_reg      <= fail_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;
        loss_next  = loss_reg;

        unique case (state_reg)
            ASSERT_RST: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == RST_LAST) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                cnt_next = cnt_reg + 1'b1;
                if (bus.relock_req_i) begin
                    state_next = ASSERT_RST;
                end else if (locked_s) begin
                    state_next = STABLE;
                end else if (cnt_reg == TO_LAST) begin
                    if (retry_reg == RETRY_MAX) begin
                        state_next = FAIL;
                    end else begin
                        retry_next = retry_reg + 1'b1;
                        state_next = ASSERT_RST;
                    end
                end
            end
            STABLE: begin
                cnt_next = cnt_reg + 1'b1;
                if (bus.relock_req_i)          state_next = ASSERT_RST;
                else if (!locked_s)            state_next = WAIT_LOCK;
                else if (cnt_reg == STABLE_LAST) state_next = RUN;
            end
            RUN: begin
                // A lock drop takes precedence so a coincident relock never hides a loss.
                if (!locked_s) begin
                    if (loss_reg != LOSS_SAT) loss_next = loss_reg + 1'b1;
                    state_next = ASSERT_RST;
                end else if (bus.relock_req_i) begin
                    state_next = ASSERT_RST;
                end
            end
            FAIL: begin
                if (bus.relock_req_i) begin
                    retry_next = '0;
                    state_next = ASSERT_RST;
                end
            end
            default: state_next = ASSERT_RST;
        endcase

        if (state_next != state_reg) cnt_next = '0;
        if (state_next == RUN)       retry_next = '0;
    end

    // Outputs decode the next state so they switch on the same edge as state_reg.
    always_comb begin
        mmcm_rst_next  = (state_next == ASSERT_RST) || (state_next == FAIL);
        sys_rst_n_next = (state_next == RUN);
        ready_next     = (state_next == RUN);
        fail_next      = (state_next == FAIL);
    end

    assign bus.mmcm_rst_o      = mmcm_rst_reg;
    assign bus.sys_rst_n_o     = sys_rst_n_reg;
    assign bus.ready_o         = ready_reg;
    assign bus.fail_o          = fail_reg;
    assign bus.retry_cnt_o     = retry_reg;
    assign bus.lock_loss_cnt_o = loss_reg;

endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
// Directed bench for mmcm_lock_supervisor with small timing parameters.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mmcm_lock_supervisor;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   compared = 0;
    int   mismatched = 0;

    mmcm_lock_supervisor_if bus();

    mmcm_lock_supervisor #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_TIMEOUT_CYCLES (20),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2),
        .SYNC_STAGES         (2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sel(input int which);
        case (which)
            0:       return bus.mmcm_rst_o;
            1:       return bus.sys_rst_n_o;
            2:       return bus.ready_o;
            default: return bus.fail_o;
        endcase
    endfunction

    // Counts falling edges until the selected output reaches val; bounded.
    task automatic wait_for(input string tag, input int which, input logic val, input int exp_n);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (sel(which) !== val && n < 300);
        check(tag, n, exp_n);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_mmcm_rst"},  bus.mmcm_rst_o, 1);
        check({pfx, "_sys_rst_n"}, bus.sys_rst_n_o, 0);
        check({pfx, "_ready"},     bus.ready_o, 0);
        check({pfx, "_fail"},      bus.fail_o, 0);
        check({pfx, "_retry"},     bus.retry_cnt_o, 0);
        check({pfx, "_loss"},      bus.lock_loss_cnt_o, 0);
    endtask

    initial begin
        bus.mmcm_locked_i = 1'b0;
        bus.relock_req_i  = 1'b0;
        reset_n = 1'b0;
        step(3);
        check_reset_vals("reset");

        // Test 1: reset pulse length and first lock.
        reset_n = 1'b1;
        step(1);
        check("t1_rst_c1", bus.mmcm_rst_o, 1);
        step(2);
        check("t1_rst_c3", bus.mmcm_rst_o, 1);
        step(1);
        check("t1_rst_c4", bus.mmcm_rst_o, 0);
        step(6);
        bus.mmcm_locked_i = 1'b1;
        wait_for("t1_ready_rise", 2, 1'b1, 11);
        check("t1_sys_rst_n", bus.sys_rst_n_o, 1);
        check("t1_fail", bus.fail_o, 0);
        check("t1_mmcm_rst", bus.mmcm_rst_o, 0);
        check("t1_retry", bus.retry_cnt_o, 0);
        $display("t1 done: ready=%0d loss=%0d", bus.ready_o, bus.lock_loss_cnt_o);

        // Test 4: single-cycle lock drop in RUN.
        bus.mmcm_locked_i = 1'b0;
        step();
        bus.mmcm_locked_i = 1'b1;
        wait_for("t4_sys_rst_fall", 1, 1'b0, 2);
        check("t4_loss", bus.lock_loss_cnt_o, 1);
        check("t4_mmcm_rst", bus.mmcm_rst_o, 1);
        check("t4_ready", bus.ready_o, 0);
        wait_for("t4_rst_pulse", 0, 1'b0, 4);
        wait_for("t4_relock", 2, 1'b1, 9);
        $display("t4 done: loss=%0d", bus.lock_loss_cnt_o);

        // Test 5: relock request coincident with synced lock drop.
        bus.mmcm_locked_i = 1'b0;
        step();
        bus.mmcm_locked_i = 1'b1;
        step();
        bus.relock_req_i = 1'b1;
        step();
        bus.relock_req_i = 1'b0;
        check("t5_loss", bus.lock_loss_cnt_o, 2);
        check("t5_mmcm_rst", bus.mmcm_rst_o, 1);
        check("t5_ready", bus.ready_o, 0);
        wait_for("t5_relock", 2, 1'b1, 13);

        // Plain relock in RUN: restart without counting a loss.
        bus.relock_req_i = 1'b1;
        step();
        bus.relock_req_i = 1'b0;
        check("t5b_loss", bus.lock_loss_cnt_o, 2);
        check("t5b_mmcm_rst", bus.mmcm_rst_o, 1);
        check("t5b_sys_rst_n", bus.sys_rst_n_o, 0);
        wait_for("t5b_relock", 2, 1'b1, 13);
        $display("t5 done: loss=%0d", bus.lock_loss_cnt_o);

        // Test 4 continued: loss counter saturation.
        for (int i = 3; i <= 256; i++) begin
            bus.mmcm_locked_i = 1'b0;
            step();
            bus.mmcm_locked_i = 1'b1;
            wait_for("sat_drop", 1, 1'b0, 2);
            check("sat_loss", bus.lock_loss_cnt_o, (i > 255) ? 255 : i);
            wait_for("sat_relock", 2, 1'b1, 13);
        end
        $display("sat done: loss=%0d", bus.lock_loss_cnt_o);

        // Test 2: lock never arrives, retries exhaust into FAIL.
        reset_n = 1'b0;
        bus.mmcm_locked_i = 1'b0;
        step(2);
        check_reset_vals("t2_reset");
        reset_n = 1'b1;
        wait_for("t2_a0_rst", 0, 1'b0, 4);
        check("t2_a0_retry", bus.retry_cnt_o, 0);
        wait_for("t2_a0_wait", 0, 1'b1, 20);
        check("t2_a1_retry", bus.retry_cnt_o, 1);
        wait_for("t2_a1_rst", 0, 1'b0, 4);
        wait_for("t2_a1_wait", 0, 1'b1, 20);
        check("t2_a2_retry", bus.retry_cnt_o, 2);
        wait_for("t2_a2_rst", 0, 1'b0, 4);
        wait_for("t2_fail_rise", 3, 1'b1, 20);
        check("t2_fail_mmcm_rst", bus.mmcm_rst_o, 1);
        check("t2_fail_retry", bus.retry_cnt_o, 2);
        check("t2_fail_ready", bus.ready_o, 0);
        step(10);
        check("t2_sticky_fail", bus.fail_o, 1);
        check("t2_sticky_mmcm_rst", bus.mmcm_rst_o, 1);
        bus.relock_req_i = 1'b1;
        step();
        bus.relock_req_i = 1'b0;
        check("t2_relock_fail", bus.fail_o, 0);
        check("t2_relock_retry", bus.retry_cnt_o, 0);
        check("t2_relock_mmcm_rst", bus.mmcm_rst_o, 1);
        $display("t2 done: fail=%0d retry=%0d", bus.fail_o, bus.retry_cnt_o);

        // Test 6: reset in WAIT_LOCK with one retry used.
        wait_for("t6_a0_rst", 0, 1'b0, 4);
        wait_for("t6_a0_wait", 0, 1'b1, 20);
        check("t6_retry_pre", bus.retry_cnt_o, 1);
        wait_for("t6_a1_rst", 0, 1'b0, 4);
        step(5);
        check("t6_retry_wait", bus.retry_cnt_o, 1);
        reset_n = 1'b0;
        step();
        check_reset_vals("t6");
        reset_n = 1'b1;
        $display("t6 done: retry=%0d mmcm_rst=%0d", bus.retry_cnt_o, bus.mmcm_rst_o);

        // Test 3: short lock glitch during STABLE, then a full hold.
        wait_for("t3_rst", 0, 1'b0, 4);
        bus.mmcm_locked_i = 1'b1;
        step(5);
        bus.mmcm_locked_i = 1'b0;
        step(3);
        check("t3_glitch_ready", bus.ready_o, 0);
        check("t3_glitch_sys_rst_n", bus.sys_rst_n_o, 0);
        check("t3_glitch_mmcm_rst", bus.mmcm_rst_o, 0);
        check("t3_glitch_retry", bus.retry_cnt_o, 0);
        bus.mmcm_locked_i = 1'b1;
        wait_for("t3_ready_rise", 2, 1'b1, 11);
        check("t3_run_retry", bus.retry_cnt_o, 0);
        $display("t3 done: ready=%0d", bus.ready_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
